wave_sequencer: RTL and testbench

Sequences the 8-bit waveform ROM (`wave`). A phase accumulator generates ROM addresses at a programmable step. Each ROM word is captured and presented to a downstream consumer over a valid/ready stream. Sits between the processor's control registers (start/stop/step/count/mode) and any sample consumer, e.g. the output port or a DAC shim.

---
 rtl/wave_seq_pkg.sv | 18 +
 rtl/wave_phase_acc.sv | 46 ++++
 rtl/wave_sequencer.sv | 152 +++++++++++++++
 tb/tb_wave_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_seq_pkg.sv
// ============================================================================
// Module  : wave_seq_pkg
// Brief   : Shared types and widths for the waveform sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package wave_seq_pkg;
   localparam int ADDR_W  = 8;
   localparam int FRAC_W  = 8;
   localparam int PHASE_W = ADDR_W + FRAC_W;
   localparam int CNT_W   = 9;

   typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} seq_state_t;
   typedef logic [PHASE_W-1:0] phase_t;
endpackage

`default_nettype wire

// File: rtl/wave_phase_acc.sv
// ============================================================================
// Module  : wave_phase_acc
// Brief   : Phase accumulator; the integer part of the phase addresses the ROM.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wave_phase_acc #(
   parameter int PHASE_W = 16,
   parameter int FRAC_W  = 8
) (
   input  logic                      clk,
   input  logic                      n_reset,
   input  logic                      load,
   input  logic [PHASE_W-1:0]        load_val,
   input  logic                      advance,
   input  logic [PHASE_W-1:0]        step,
   output logic [PHASE_W-1:0]        phase,
   output logic [PHASE_W-FRAC_W-1:0] addr
);
   logic [PHASE_W-1:0] phase_q;
   logic [PHASE_W-1:0] phase_d;

   // Sum wraps modulo 2^PHASE_W, so the address rolls over with no special case.
   always_comb begin
      phase_d = phase_q;
      if (load) begin
         phase_d = load_val;
      end else if (advance) begin
         phase_d = phase_q + step;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;
   assign addr  = phase_q[PHASE_W-1:FRAC_W];
endmodule

`default_nettype wire

// File: rtl/wave_sequencer.sv
// ============================================================================
// Module  : wave_sequencer
// Brief   : Steps through the waveform ROM and streams samples over valid/ready.
//           Define SEQ_GAIN_EN to scale each captured sample by cfg_gain/256.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wave_sequencer #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int FRAC_W = 8,
   parameter int CNT_W  = 9
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     start,
   input  logic                     stop,
   input  logic [ADDR_W-1:0]        cfg_start_addr,
   input  logic [ADDR_W+FRAC_W-1:0] cfg_step,
   input  logic [CNT_W-1:0]         cfg_count,
   input  logic                     cfg_continuous,
   input  logic [7:0]               cfg_gain,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic [DATA_W-1:0]        rom_data,
   output logic [DATA_W-1:0]        sample,
   output logic                     sample_valid,
   input  logic                     sample_ready,
   output logic                     busy,
   output logic                     done
);
   localparam int PW = ADDR_W + FRAC_W;

   import wave_seq_pkg::*;

   seq_state_t        state_q;
   logic [CNT_W-1:0]  count_q;
   logic [PW-1:0]     step_q;
   logic              cont_q;
   logic              stop_pend_q;
   logic [DATA_W-1:0] sample_q;
   logic              valid_q;
   logic              done_q;

   logic              w_load;
   logic              w_advance;
   logic              w_more;
   logic [PW-1:0]     w_phase;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_sample;
   logic              w_unused;

   // A stop seen in the handshake cycle itself also ends the run.
   assign w_more    = (cont_q || (count_q != '0)) && !stop_pend_q && !stop;
   assign w_load    = (state_q == IDLE) && start && !stop;
   assign w_advance = (state_q == FETCH) ||
                      ((state_q == PRESENT) && sample_ready && w_more);

   wave_phase_acc #(
      .PHASE_W (PW),
      .FRAC_W  (FRAC_W)
   ) u_phase_acc (
      .clk      (clk),
      .n_reset  (n_reset),
      .load     (w_load),
      .load_val ({cfg_start_addr, {FRAC_W{1'b0}}}),
      .advance  (w_advance),
      .step     (step_q),
      .phase    (w_phase),
      .addr     (w_addr)
   );

`ifdef SEQ_GAIN_EN
   logic [7:0]          gain_q;
   logic [DATA_W+7:0]   w_prod;
   assign w_prod   = (DATA_W+8)'(rom_data) * (DATA_W+8)'(gain_q);
   assign w_sample = DATA_W'(w_prod >> 8);
   assign w_unused = ^w_phase;
`else
   assign w_sample = rom_data;
   assign w_unused = ^{cfg_gain, w_phase};
`endif

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         step_q      <= '0;
         cont_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         sample_q    <= '0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
`ifdef SEQ_GAIN_EN
         gain_q      <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start && !stop) begin
                  step_q  <= cfg_step;
                  count_q <= cfg_count;
                  cont_q  <= cfg_continuous;
`ifdef SEQ_GAIN_EN
                  gain_q  <= cfg_gain;
`endif
                  if ((cfg_count == '0) && !cfg_continuous) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= FETCH;
                  end
               end
            end
            FETCH: begin
               sample_q <= w_sample;
               valid_q  <= 1'b1;
               count_q  <= count_q - 1'b1;
               if (stop) stop_pend_q <= 1'b1;
               state_q  <= PRESENT;
            end
            PRESENT: begin
               if (stop) stop_pend_q <= 1'b1;
               if (sample_ready) begin
                  if (w_more) begin
                     sample_q <= w_sample;
                     count_q  <= count_q - 1'b1;
                  end else begin
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               stop_pend_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rom_addr     = w_addr;
   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign done         = done_q;
   assign busy         = (state_q != IDLE);
endmodule

`default_nettype wire

// File: tb/tb_wave_sequencer.sv
// ============================================================================
// Module  : tb_wave_sequencer
// Brief   : Scoreboard bench for wave_sequencer with a modelled waveform ROM.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wave_sequencer;
   logic        clk = 1'b0;
   logic        n_reset;
   logic        start, stop;
   logic [7:0]  cfg_start_addr;
   logic [15:0] cfg_step;
   logic [8:0]  cfg_count;
   logic        cfg_continuous;
   logic [7:0]  cfg_gain;
   logic [7:0]  rom_addr;
   logic [7:0]  rom_data;
   logic [7:0]  sample;
   logic        sample_valid;
   logic        sample_ready;
   logic        busy;
   logic        done;

   logic [7:0]  rom [256];
   logic [7:0]  exp_q [$];
   int          total = 0;
   int          bad = 0;
   int          xfer_cnt = 0;

   always #5 clk = ~clk;

   assign rom_data = rom[rom_addr];

   wave_sequencer dut (
      .clk            (clk),
      .n_reset        (n_reset),
      .start          (start),
      .stop           (stop),
      .cfg_start_addr (cfg_start_addr),
      .cfg_step       (cfg_step),
      .cfg_count      (cfg_count),
      .cfg_continuous (cfg_continuous),
      .cfg_gain       (cfg_gain),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .sample         (sample),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .busy           (busy),
      .done           (done)
   );

   function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] g);
`ifdef SEQ_GAIN_EN
      logic [15:0] p;
      p = 16'(rom[a]) * 16'(g);
      return p[15:8];
`else
      return (g == g) ? rom[a] : 8'h00;
`endif
   endfunction

   task automatic push_run(input logic [7:0] sa, input logic [15:0] st, input int n,
                           input logic [7:0] g);
      logic [15:0] ph;
      ph = {sa, 8'h00};
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(model(ph[15:8], g));
         ph = ph + st;
      end
   endtask

   task automatic drive_start(input logic [7:0] sa, input logic [15:0] st, input logic [8:0] n,
                              input logic cont, input logic [7:0] g);
      cfg_start_addr = sa;
      cfg_step       = st;
      cfg_count      = n;
      cfg_continuous = cont;
      cfg_gain       = g;
      start          = 1'b1;
   endtask

   task automatic wait_done(input int max, input logic [3:0] pat, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
         sample_ready = pat[i % 4];
      end
      if (ok) begin
         @(posedge clk); #1;
      end
   endtask

   // Scoreboard and hold-stability monitor.
   initial begin
      bit         hold_prev;
      logic [7:0] hold_sample;
      logic [7:0] e;
      hold_prev = 1'b0;
      hold_sample = '0;
      forever begin
         @(negedge clk);
         if (n_reset !== 1'b1) begin
            hold_prev = 1'b0;
         end else begin
            if (hold_prev) begin
               total++;
               if (sample_valid !== 1'b1 || sample !== hold_sample) begin
                  bad++;
                  $display("FAIL hold_stable: valid=%b sample=%h required valid=1 sample=%h",
                           sample_valid, sample, hold_sample);
               end
            end
            if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
               total++;
               xfer_cnt++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_xfer: sample=%h required no transfer", sample);
               end else begin
                  e = exp_q.pop_front();
                  if (sample !== e) begin
                     bad++;
                     $display("FAIL sample_data: got=%h required=%h", sample, e);
                  end
               end
            end
            hold_prev   = (sample_valid === 1'b1) && (sample_ready !== 1'b1);
            hold_sample = sample;
         end
      end
   end

   task automatic test_reset();
      n_reset = 1'b0;
      start = 1'b0; stop = 1'b0; sample_ready = 1'b0;
      cfg_start_addr = 8'h00; cfg_step = 16'h0100; cfg_count = 9'd0;
      cfg_continuous = 1'b0; cfg_gain = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (rom_addr !== 8'h00 || sample_valid !== 1'b0 || done !== 1'b0 ||
          busy !== 1'b0 || sample !== 8'h00) begin
         bad++;
         $display("FAIL reset_state: addr=%h valid=%b done=%b busy=%b sample=%h required all zero",
                  rom_addr, sample_valid, done, busy, sample);
      end
      n_reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_one_shot();
      int base;
      base = xfer_cnt;
      push_run(8'h00, 16'h0100, 4, 8'hFF);
      sample_ready = 1'b1;
      drive_start(8'h00, 16'h0100, 9'd4, 1'b0, 8'hFF);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         total++;
         if (sample_valid !== ((c >= 2 && c <= 5) ? 1'b1 : 1'b0)) begin
            bad++;
            $display("FAIL one_shot_valid c%0d: got=%b required=%b", c, sample_valid,
                     (c >= 2 && c <= 5));
         end
         total++;
         if (done !== ((c == 6) ? 1'b1 : 1'b0)) begin
            bad++;
            $display("FAIL one_shot_done c%0d: got=%b required=%b", c, done, (c == 6));
         end
         total++;
         if (busy !== ((c >= 1 && c <= 6) ? 1'b1 : 1'b0)) begin
            bad++;
            $display("FAIL one_shot_busy c%0d: got=%b required=%b", c, busy, (c >= 1 && c <= 6));
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      total++;
      if (xfer_cnt - base != 4 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL one_shot_count: xfers=%0d left=%0d required 4 and 0",
                  xfer_cnt - base, exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      int base;
      bit ok;
      base = xfer_cnt;
      push_run(8'h00, 16'h0100, 4, 8'hFF);
      sample_ready = 1'b0;
      drive_start(8'h00, 16'h0100, 9'd4, 1'b0, 8'hFF);
      @(posedge clk); #1;
      start = 1'b0;
      cfg_step = 16'h0700;
      cfg_start_addr = 8'h55;
      cfg_count = 9'd9;
      wait_done(60, 4'b1001, ok);
      sample_ready = 1'b1;
      total++;
      if (!ok || xfer_cnt - base != 4 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL backpressure: done=%b xfers=%0d left=%0d required 1, 4, 0",
                  ok, xfer_cnt - base, exp_q.size());
      end
   endtask

   task automatic test_wrap();
      int base;
      bit ok;
      base = xfer_cnt;
      push_run(8'd254, 16'h0080, 6, 8'hFF);
      sample_ready = 1'b1;
      drive_start(8'd254, 16'h0080, 9'd6, 1'b0, 8'hFF);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(40, 4'b1111, ok);
      total++;
      if (!ok || xfer_cnt - base != 6 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL wrap: done=%b xfers=%0d left=%0d required 1, 6, 0",
                  ok, xfer_cnt - base, exp_q.size());
      end
   endtask

   task automatic test_stop();
      int base;
      bit ok;
      base = xfer_cnt;
      push_run(8'h10, 16'h0100, 3, 8'hFF);
      sample_ready = 1'b1;
      drive_start(8'h10, 16'h0100, 9'd0, 1'b1, 8'hFF);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (xfer_cnt - base >= 2) break;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      sample_ready = 1'b0;
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      sample_ready = 1'b1;
      wait_done(20, 4'b1111, ok);
      total++;
      if (!ok || xfer_cnt - base != 3 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL stop_midrun: done=%b xfers=%0d left=%0d required 1, 3, 0",
                  ok, xfer_cnt - base, exp_q.size());
      end
   endtask

   task automatic test_edges();
      // Zero-count one-shot: done on the next cycle, nothing presented.
      drive_start(8'h30, 16'h0100, 9'd0, 1'b0, 8'hFF);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (sample_valid !== 1'b0 || done !== ((c == 1) ? 1'b1 : 1'b0)) begin
            bad++;
            $display("FAIL zero_count c%0d: valid=%b done=%b required valid=0 done=%b",
                     c, sample_valid, done, (c == 1));
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      drive_start(8'h30, 16'h0100, 9'd4, 1'b0, 8'hFF);
      stop = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      stop = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b0 || sample_valid !== 1'b0) begin
            bad++;
            $display("FAIL start_stop c%0d: busy=%b valid=%b required 0 0", c, busy, sample_valid);
         end
         @(posedge clk); #1;
      end
      sample_ready = 1'b0;
      drive_start(8'h20, 16'h0100, 9'd4, 1'b0, 8'hFF);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      total++;
      if (sample_valid !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset_valid: got=%b required=1", sample_valid);
      end
      n_reset = 1'b0;
      #1;
      total++;
      if (sample_valid !== 1'b0 || rom_addr !== 8'h00 || busy !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: valid=%b addr=%h busy=%b required 0 00 0",
                  sample_valid, rom_addr, busy);
      end
      exp_q.delete();
      @(posedge clk); #1;
      n_reset = 1'b1;
      sample_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_gain();
      int base;
      bit ok;
      base = xfer_cnt;
      push_run(8'h40, 16'h0100, 5, 8'h80);
      sample_ready = 1'b1;
      drive_start(8'h40, 16'h0100, 9'd5, 1'b0, 8'h80);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(40, 4'b1111, ok);
      total++;
      if (!ok || xfer_cnt - base != 5 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL gain: done=%b xfers=%0d left=%0d required 1, 5, 0",
                  ok, xfer_cnt - base, exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         rom[i] = 8'((i * 73) + 29);
      end
      test_reset();
      test_one_shot();
      test_backpressure();
      test_wrap();
      test_stop();
      test_edges();
      test_gain();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

`default_nettype wire
